scan_display_decoder: RTL
=========================

Name: scan_display_decoder

Overview:
- Receive-side counterpart of the clock's multiplexed 7-segment display driver: observes the digit-select (led_bits) and segment (sm_a_to_g) lines and reconstructs the displayed time as packed BCD.
- Used as an on-board self-check and bench monitor that confirms the display path shows the counted time, and as the time source for the planned alarm comparator.
- Validates scan timing, segment patterns and BCD ranges.
- Publishes a time snapshot only after consecutive matching frames.

Parameters:
STABLE_CYCLES, 4, consecutive cycles a select/segment pair must hold unchanged before the digit is captured (1..255)
MATCH_FRAMES, 2, consecutive identical complete frames required before publishing (1..15)
TIMEOUT_CYCLES, 65536, cycles without a completed frame before lock is dropped (must be > 6*STABLE_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
led_bits  in  8  digit select, one-hot; bit0=sec units, 1=sec tens, 2=min units, 3=min tens, 4=hour units, 5=hour tens; 8'h00 = blank
sm_a_to_g  in  7  segment pattern, bit6=a … bit0=g, 1=lit
second  out  8  published seconds, BCD {tens,units}
minute  out  8  published minutes, BCD
hour  out  8  published hours, BCD
time_valid  out  1  one-cycle pulse when second/minute/hour update
locked  out  1  high while published time is current
seg_err  out  1  sticky: undecodable segment pattern captured
sel_err  out  1  sticky: led_bits not one-hot/zero, or bit 7/6 set
range_err  out  1  sticky: completed frame failed the BCD range check

Behaviour:
- Reset: all outputs 0; capture mask, match counter, timeout counter and stability counter cleared; FSM enters IDLE. Reset mid-frame discards all partial data.
- Segment decode, combinational: 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9. Any other pattern is invalid.
- Stability counter:
  - Increments while {led_bits, sm_a_to_g} equals its previous-cycle value; resets to 0 on any change.
  - The capture event fires exactly once, in the cycle the counter reaches STABLE_CYCLES-1, and only for a single legal select bit (0..5).
- Blank or illegal select: never captured and does not break the frame. Illegal select (more than one bit set, or bit 6/7 set) sets sel_err.
- Invalid pattern at the capture event: sets seg_err; the frame is aborted (mask cleared, FSM back to WAIT_START).
- FSM:
  - IDLE: on leaving reset → WAIT_START.
  - WAIT_START: on a capture event at position 0 → COLLECT; store the digit and set mask bit 0.
  - COLLECT: a capture event at position p stores the digit and sets mask[p]; a recapture overwrites. A capture at position 0 while mask==6'h3F ends the frame → CHECK, and that position-0 digit starts the next frame's buffer. A capture at position 0 with an incomplete mask restarts the frame (mask=6'b000001).
  - CHECK (1 cycle), range check: sec tens ≤5, min tens ≤5, hour tens ≤2, and hour ≤ 8'h23.
    - Fail: range_err=1, match counter=0, timeout counter cleared → COLLECT.
    - Pass, frame equals last completed frame: match counter increments, saturating at 15. Otherwise the match counter is set to 1. Timeout counter cleared.
    - When the match counter ≥ MATCH_FRAMES and the frame differs from the current outputs: second/minute/hour load on the cycle after CHECK, time_valid pulses that same cycle, locked=1.
    - Identical republish: no pulse.
    - Return → COLLECT.
- Timeout counter: increments every cycle outside CHECK. On reaching TIMEOUT_CYCLES-1: locked=0, match counter=0, FSM → WAIT_START. Outputs hold their last value.
- Sticky errors clear only on rst. Error detection and a capture in the same cycle: both take effect.
- Latency: last digit stable → CHECK after STABLE_CYCLES; publish on the CHECK cycle +1.

Test Plan:
- Scan 12:34:56 continuously, 4000 cycles/digit, positions 0..5 in order → after the 2nd complete frame: second=8'h56, minute=8'h34, hour=8'h12, one time_valid pulse, locked=1, no error flags.
- Scan 23:59:59, then switch to 00:00:00 mid-frame → 00:00:00 published after 2 matching frames, exactly one further time_valid pulse, no intermediate mixed value.
- Scan 12:34:56 with the min-units pattern 1010101 (invalid) → seg_err=1, outputs stay 0, locked=0; after valid frames resume, 12:34:56 is published and seg_err stays 1.
- Scan hour 8'h25 (patterns for 2,5) → range_err=1 every frame, nothing published.
- led_bits=8'b00000011 for 10 cycles, and 8'h80 glitches → sel_err=1, no capture occurs.
- Locked on 12:34:56, then hold led_bits=0 for TIMEOUT_CYCLES → locked falls to 0, hour/minute/second hold 12/34/56; rst asserted mid-frame → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/scan_display_decoder_if.sv
// Display scan lines observed by the decoder and the time/status it reconstructs.
interface scan_display_decoder_if;
  logic [7:0] led_bits;
  logic [6:0] sm_a_to_g;
  logic [7:0] second;
  logic [7:0] minute;
  logic [7:0] hour;
  logic       time_valid;
  logic       locked;
  logic       seg_err;
  logic       sel_err;
  logic       range_err;

  modport master (
    output led_bits, sm_a_to_g,
    input  second, minute, hour, time_valid, locked, seg_err, sel_err, range_err
  );

  modport slave (
    input  led_bits, sm_a_to_g,
    output second, minute, hour, time_valid, locked, seg_err, sel_err, range_err
  );
endinterface

// File: rtl/scan_display_decoder.sv
// Rebuilds the displayed time from a multiplexed 7-segment scan and publishes it
// as packed BCD once enough consecutive complete frames agree.
module scan_display_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int MATCH_FRAMES   = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  scan_display_decoder_if.slave bus
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0]    STAB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [3:0]    MATCH_LIM = 4'(MATCH_FRAMES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_START, COLLECT, CHECK} state_t;

  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: return {1'b1, 4'd0};
      7'b0110000: return {1'b1, 4'd1};
      7'b1101101: return {1'b1, 4'd2};
      7'b1111001: return {1'b1, 4'd3};
      7'b0110011: return {1'b1, 4'd4};
      7'b1011011: return {1'b1, 4'd5};
      7'b1011111: return {1'b1, 4'd6};
      7'b1110000: return {1'b1, 4'd7};
      7'b1111111: return {1'b1, 4'd8};
      7'b1111011: return {1'b1, 4'd9};
      default:    return 5'b0_0000;
    endcase
  endfunction

  function automatic logic range_ok(input logic [23:0] f);
    return (f[7:4] <= 4'd5) && (f[15:12] <= 4'd5) &&
           (f[23:20] <= 4'd2) && (f[23:16] <= 8'h23);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  state_t        r_state, w_state_nxt;
  logic [14:0]   r_prev;
  logic [7:0]    r_stab;
  logic [23:0]   r_buf, r_frame, r_last;
  logic          r_last_vld;
  logic [5:0]    r_mask, w_mask_nxt;
  logic [3:0]    r_match, w_match_nxt;
  logic [TW-1:0] r_tmo;

  logic [14:0] w_cur;
  logic        w_same, w_sel_bad, w_prev_sel_ok, w_cap, w_dec_ok;
  logic [3:0]  w_digit;
  logic [2:0]  w_pos;
  logic        w_store, w_snap, w_seg_bad, w_tmo_hit;
  logic        w_rng_ok, w_same_last, w_pub, w_new;

  assign w_cur         = {bus.led_bits, bus.sm_a_to_g};
  assign w_same        = (w_cur == r_prev);
  assign w_sel_bad     = (bus.led_bits[7:6] != 2'b00) ||
                         ((bus.led_bits[5:0] & (bus.led_bits[5:0] - 6'd1)) != 6'd0);
  assign w_prev_sel_ok = (r_prev[14:13] == 2'b00) && $onehot(r_prev[12:7]);
  // The counter passes STAB_LAST exactly once per held value (it saturates at 255).
  assign w_cap         = (r_stab == STAB_LAST) && w_prev_sel_ok;
  assign {w_dec_ok, w_digit} = seg_decode(r_prev[6:0]);

  always_comb begin
    w_pos = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (r_prev[7+i]) w_pos = 3'(i);
    end
  end

  assign w_rng_ok    = range_ok(r_frame);
  assign w_same_last = r_last_vld && (r_frame == r_last);
  assign w_match_nxt = !w_rng_ok ? 4'd0 : (w_same_last ? sat_inc(r_match) : 4'd1);
  assign w_pub       = w_rng_ok && (w_match_nxt >= MATCH_LIM);
  assign w_new       = (r_frame != {bus.hour, bus.minute, bus.second});
  assign w_tmo_hit   = (r_state != CHECK) && (r_tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_store     = 1'b0;
    w_snap      = 1'b0;
    w_seg_bad   = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = WAIT_START;
      WAIT_START: begin
        if (w_cap && !w_dec_ok) begin
          w_seg_bad = 1'b1;
        end else if (w_cap && w_pos == 3'd0) begin
          w_store     = 1'b1;
          w_mask_nxt  = 6'b000001;
          w_state_nxt = COLLECT;
        end
      end
      default: begin
        if (r_state == CHECK) w_state_nxt = COLLECT;
        if (w_cap && !w_dec_ok) begin
          w_seg_bad   = 1'b1;
          w_mask_nxt  = 6'b000000;
          w_state_nxt = WAIT_START;
        end else if (w_cap && w_pos == 3'd0) begin
          // Position 0 both closes a full frame and opens the next one.
          w_store    = 1'b1;
          w_mask_nxt = 6'b000001;
          if (r_state == COLLECT && r_mask == 6'h3F) begin
            w_snap      = 1'b1;
            w_state_nxt = CHECK;
          end
        end else if (w_cap) begin
          w_store    = 1'b1;
          w_mask_nxt = r_mask | (6'b000001 << w_pos);
        end
      end
    endcase
    if (w_tmo_hit) begin
      w_state_nxt = WAIT_START;
      w_mask_nxt  = 6'b000000;
      w_store     = 1'b0;
      w_snap      = 1'b0;
    end
  end

  // Digit buffer and frame snapshots carry no reset; r_mask/r_last_vld qualify them.
  always_ff @(posedge clk) begin
    if (w_store) r_buf[{w_pos, 2'b00} +: 4] <= w_digit;
    if (w_snap) r_frame <= r_buf;
    if (r_state == CHECK && w_rng_ok) r_last <= r_frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev         <= '0;
      r_stab         <= '0;
      r_mask         <= '0;
      r_match        <= '0;
      r_tmo          <= '0;
      r_last_vld     <= 1'b0;
      bus.second     <= '0;
      bus.minute     <= '0;
      bus.hour       <= '0;
      bus.time_valid <= 1'b0;
      bus.locked     <= 1'b0;
      bus.seg_err    <= 1'b0;
      bus.sel_err    <= 1'b0;
      bus.range_err  <= 1'b0;
    end else begin
      r_prev         <= w_cur;
      r_stab         <= !w_same ? 8'd0 : ((r_stab == 8'hFF) ? r_stab : r_stab + 8'd1);
      r_mask         <= w_mask_nxt;
      bus.time_valid <= 1'b0;
      if (w_sel_bad) bus.sel_err <= 1'b1;
      if (w_seg_bad) bus.seg_err <= 1'b1;
      if (r_state == CHECK) begin
        r_tmo   <= '0;
        r_match <= w_match_nxt;
        if (!w_rng_ok) begin
          bus.range_err <= 1'b1;
        end else begin
          r_last_vld <= 1'b1;
          if (w_pub) begin
            bus.locked <= 1'b1;
            if (w_new) begin
              {bus.hour, bus.minute, bus.second} <= r_frame;
              bus.time_valid <= 1'b1;
            end
          end
        end
      end else if (w_tmo_hit) begin
        r_tmo      <= '0;
        r_match    <= '0;
        bus.locked <= 1'b0;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end
    end
  end

endmodule
